// File: rtl/e_stage_reg.sv
// e_stage_reg: decode-to-execute pipeline register with bubble and async clear.
// Ports:
//   clk, reset (async, active-high)
//   E_bubble (loads an all-zero NOP instead of the D inputs)
//   D_op, D_func, D_valC, d_valA, d_valB, d_dstE, d_dstM, d_srcA, d_srcB (decode stage inputs)
//   E_op, E_func, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB (registered outputs)
module e_stage_reg (
   output logic [5:0]  E_op,
   output logic [5:0]  E_func,
   output logic [31:0] E_valC,
   output logic [31:0] E_valA,
   output logic [31:0] E_valB,
   output logic [4:0]  E_dstE,
   output logic [4:0]  E_dstM,
   output logic [4:0]  E_srcA,
   output logic [4:0]  E_srcB,
   input  logic        clk,
   input  logic        E_bubble,
   input  logic [5:0]  D_op,
   input  logic [5:0]  D_func,
   input  logic [31:0] D_valC,
   input  logic [31:0] d_valA,
   input  logic [31:0] d_valB,
   input  logic [4:0]  d_dstE,
   input  logic [4:0]  d_dstM,
   input  logic [4:0]  d_srcA,
   input  logic [4:0]  d_srcB,
   input  logic        reset
);

   logic [5:0]  r_op;
   logic [5:0]  r_func;
   logic [31:0] r_valC;
   logic [31:0] r_valA;
   logic [31:0] r_valB;
   logic [4:0]  r_dstE;
   logic [4:0]  r_dstM;
   logic [4:0]  r_srcA;
   logic [4:0]  r_srcB;

   // The NOP is all-zero: sll $0,$0,0 with $0 specifiers, so no
   // writeback and no forwarding match downstream.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op   <= '0;
         r_func <= '0;
         r_valC <= '0;
         r_valA <= '0;
         r_valB <= '0;
         r_dstE <= '0;
         r_dstM <= '0;
         r_srcA <= '0;
         r_srcB <= '0;
      end else if (E_bubble) begin
         r_op   <= '0;
         r_func <= '0;
         r_valC <= '0;
         r_valA <= '0;
         r_valB <= '0;
         r_dstE <= '0;
         r_dstM <= '0;
         r_srcA <= '0;
         r_srcB <= '0;
      end else begin
         r_op   <= D_op;
         r_func <= D_func;
         r_valC <= D_valC;
         r_valA <= d_valA;
         r_valB <= d_valB;
         r_dstE <= d_dstE;
         r_dstM <= d_dstM;
         r_srcA <= d_srcA;
         r_srcB <= d_srcB;
      end
   end

   assign E_op   = r_op;
   assign E_func = r_func;
   assign E_valC = r_valC;
   assign E_valA = r_valA;
   assign E_valB = r_valB;
   assign E_dstE = r_dstE;
   assign E_dstM = r_dstM;
   assign E_srcA = r_srcA;
   assign E_srcB = r_srcB;

endmodule

// File: tb/tb_e_stage_reg.sv
// tb_e_stage_reg: directed bench for the D->E pipeline register.
// Covers reset, load latency, sequences, bubble, mid-cycle reset, priority/width.
module tb_e_stage_reg;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        E_bubble = 1'b0;
   logic [5:0]  D_op = '0;
   logic [5:0]  D_func = '0;
   logic [31:0] D_valC = '0;
   logic [31:0] d_valA = '0;
   logic [31:0] d_valB = '0;
   logic [4:0]  d_dstE = '0;
   logic [4:0]  d_dstM = '0;
   logic [4:0]  d_srcA = '0;
   logic [4:0]  d_srcB = '0;
   logic [5:0]  E_op;
   logic [5:0]  E_func;
   logic [31:0] E_valC;
   logic [31:0] E_valA;
   logic [31:0] E_valB;
   logic [4:0]  E_dstE;
   logic [4:0]  E_dstM;
   logic [4:0]  E_srcA;
   logic [4:0]  E_srcB;

   int checks = 0;
   int failures = 0;

   logic [127:0] obs;
   logic [127:0] exp_v;

   e_stage_reg dut (
      .E_op(E_op), .E_func(E_func), .E_valC(E_valC),
      .E_valA(E_valA), .E_valB(E_valB),
      .E_dstE(E_dstE), .E_dstM(E_dstM),
      .E_srcA(E_srcA), .E_srcB(E_srcB),
      .clk(clk), .E_bubble(E_bubble),
      .D_op(D_op), .D_func(D_func), .D_valC(D_valC),
      .d_valA(d_valA), .d_valB(d_valB),
      .d_dstE(d_dstE), .d_dstM(d_dstM),
      .d_srcA(d_srcA), .d_srcB(d_srcB),
      .reset(reset)
   );

   always #5 clk = ~clk;

   assign obs = {E_op, E_func, E_valC, E_valA, E_valB,
                 E_dstE, E_dstM, E_srcA, E_srcB};

   // Expected output image when every field carries value v.
   function automatic logic [127:0] pat(input logic [31:0] v);
      return {v[5:0], v[5:0], v, v, v, v[4:0], v[4:0], v[4:0], v[4:0]};
   endfunction

   task automatic drive(input logic [31:0] v);
      D_op = v[5:0]; D_func = v[5:0]; D_valC = v;
      d_valA = v; d_valB = v;
      d_dstE = v[4:0]; d_dstM = v[4:0];
      d_srcA = v[4:0]; d_srcB = v[4:0];
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(32'd7);
      #2 reset = 1'b1;
      #1;
      exp_v = '0;
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL reset_async got=%h exp=%h", obs, exp_v);
      end
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL reset_held%0d got=%h exp=%h", i, obs, exp_v);
         end
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL reset_release got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_load();
      @(negedge clk);
      drive(32'd1);
      tick();
      exp_v = pat(32'd1);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL load1 got=%h exp=%h", obs, exp_v);
      end
      #2 drive(32'd2);
      #1;
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL load_noedge got=%h exp=%h", obs, exp_v);
      end
      tick();
      exp_v = pat(32'd2);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL load2 got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_sequence();
      for (int v = 1; v <= 5; v++) begin
         @(negedge clk);
         drive(32'(v));
         tick();
         exp_v = pat(32'(v));
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL seq%0d got=%h exp=%h", v, obs, exp_v);
         end
         #3;
         checks++;
         if (obs !== exp_v) begin
            failures++;
            $display("FAIL seq_hold%0d got=%h exp=%h", v, obs, exp_v);
         end
      end
   endtask

   task automatic test_bubble();
      @(negedge clk);
      drive(32'd3);
      tick();
      exp_v = pat(32'd3);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL bub_pre got=%h exp=%h", obs, exp_v);
      end
      @(negedge clk);
      drive(32'd4);
      E_bubble = 1'b1;
      tick();
      exp_v = '0;
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL bubble got=%h exp=%h", obs, exp_v);
      end
      @(negedge clk);
      E_bubble = 1'b0;
      drive(32'd5);
      tick();
      exp_v = pat(32'd5);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL bub_resume got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      exp_v = '0;
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL rst_mid got=%h exp=%h", obs, exp_v);
      end
      #1 reset = 1'b0;
      drive(32'd6);
      #1;
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL rst_mid_hold got=%h exp=%h", obs, exp_v);
      end
      tick();
      exp_v = pat(32'd6);
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL rst_mid_next got=%h exp=%h", obs, exp_v);
      end
   endtask

   task automatic test_priority();
      @(negedge clk);
      drive(32'd9);
      d_valA = 32'hFFFF_FFFF;
      reset = 1'b1;
      E_bubble = 1'b1;
      #1;
      exp_v = '0;
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL prio_async got=%h exp=%h", obs, exp_v);
      end
      tick();
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL prio_edge got=%h exp=%h", obs, exp_v);
      end
      @(negedge clk);
      reset = 1'b0;
      tick();
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL prio_bub_after_rst got=%h exp=%h", obs, exp_v);
      end
      @(negedge clk);
      E_bubble = 1'b0;
      D_op = 6'h3F; D_func = 6'h2A;
      D_valC = 32'hFFFF_FFFF;
      d_valA = 32'hFFFF_FFFF;
      d_valB = 32'hFFFF_FFFF;
      d_dstE = 5'h1F; d_dstM = 5'h03;
      d_srcA = 5'h04; d_srcB = 5'h15;
      tick();
      exp_v = {6'h3F, 6'h2A, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 5'h1F, 5'h03, 5'h04, 5'h15};
      checks++;
      if (obs !== exp_v) begin
         failures++;
         $display("FAIL width got=%h exp=%h", obs, exp_v);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_sequence();
      test_bubble();
      test_reset_mid();
      test_priority();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
